// File: rtl/fpaddsub_result_assembler.sv
// fpaddsub_result_assembler
//   Back end of the FP add/sub datapath. Takes the normalized sum from the
//   normalizer, rounds it to nearest-even (stage 1), then resolves the
//   front-end exception vector and packs the IEEE-style result (stage 2).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   in_sign           sign of the normalized result
//   in_exp            biased exponent, two's complement, EXPONENT+2 bits
//   in_mant           normalized mantissa including hidden bit (MSB)
//   in_grs            guard, round, sticky
//   in_exc            {any, a_nan, b_nan, a_inf, b_inf} from the front end
//   in_sa, in_sb      operand signs
//   in_op             0 = add, 1 = subtract
//   out_valid/out_ready downstream handshake
//   out_result        packed {sign, exponent, fraction}
//   out_flags         {invalid, overflow, underflow, inexact, zero}
module fpaddsub_result_assembler #(
  parameter int DWIDTH   = 16,
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXPONENT+1:0]   in_exp,
  input  logic [MANTISSA:0]     in_mant,
  input  logic [2:0]            in_grs,
  input  logic [4:0]            in_exc,
  input  logic                  in_sa,
  input  logic                  in_sb,
  input  logic                  in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DWIDTH-1:0]     out_result,
  output logic [4:0]            out_flags
);

  localparam int EW = EXPONENT + 2;
  // One extra bit so the rounding increment can never wrap the exponent.
  localparam int XW = EXPONENT + 3;
  localparam int MW = MANTISSA + 1;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXPONENT) - 1);
  localparam logic [DWIDTH-1:0] QNAN =
    {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q, s1_sign_d;
  logic [XW-1:0] s1_exp_q, s1_exp_d;
  logic [MW-1:0] s1_mant_q, s1_mant_d;
  logic          s1_inexact_q, s1_inexact_d;
  logic [4:0]    s1_exc_q, s1_exc_d;
  logic          s1_sa_q, s1_sa_d;
  logic          s1_sb_q, s1_sb_d;
  logic          s1_op_q, s1_op_d;

  // Stage 2 registers
  logic              s2_valid_q, s2_valid_d;
  logic [DWIDTH-1:0] s2_result_q, s2_result_d;
  logic [4:0]        s2_flags_q, s2_flags_d;

  logic s2_advance, s1_advance, accept;

  always_comb begin
    s2_advance = !s2_valid_q || out_ready;
    s1_advance = !s1_valid_q || s2_advance;
    in_ready   = s1_advance && !rst;
    accept     = in_valid && in_ready;
  end

  // Stage 1: round to nearest, ties to even
  logic          round_up;
  logic [MW:0]   mant_sum;
  logic [XW-1:0] exp_ext;
  logic [MW-1:0] mant_rnd;
  logic [XW-1:0] exp_rnd;

  always_comb begin
    round_up = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
    mant_sum = {1'b0, in_mant} + {{MW{1'b0}}, round_up};
    exp_ext  = {in_exp[EW-1], in_exp};
    if (mant_sum[MW]) begin
      // all-ones mantissa rounded up: renormalize by one place
      mant_rnd = mant_sum[MW:1];
      exp_rnd  = exp_ext + XW'(1);
    end else begin
      mant_rnd = mant_sum[MW-1:0];
      exp_rnd  = exp_ext;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_mant_d    = s1_mant_q;
    s1_inexact_d = s1_inexact_q;
    s1_exc_d     = s1_exc_q;
    s1_sa_d      = s1_sa_q;
    s1_sb_d      = s1_sb_q;
    s1_op_d      = s1_op_q;
    if (s1_advance) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_sign_d    = in_sign;
      s1_exp_d     = exp_rnd;
      s1_mant_d    = mant_rnd;
      s1_inexact_d = |in_grs;
      s1_exc_d     = in_exc;
      s1_sa_d      = in_sa;
      s1_sb_d      = in_sb;
      s1_op_d      = in_op;
    end
  end

  // Stage 2: exception resolution and packing
  logic              exc_any, a_nan, b_nan, a_inf, b_inf;
  logic              exp_le0, exp_ovf, mant_zero;
  logic              f_inv, f_ovf, f_unf, f_inx, f_zero;
  logic [DWIDTH-1:0] res_c;

  always_comb begin
    // The front end only raises individual exception bits together with any.
    exc_any   = s1_exc_q[4];
    a_nan     = exc_any & s1_exc_q[3];
    b_nan     = exc_any & s1_exc_q[2];
    a_inf     = exc_any & s1_exc_q[1];
    b_inf     = exc_any & s1_exc_q[0];
    exp_le0   = s1_exp_q[XW-1] || (s1_exp_q == '0);
    exp_ovf   = !s1_exp_q[XW-1] && (s1_exp_q >= EXP_MAX);
    mant_zero = (s1_mant_q == '0);

    res_c  = {s1_sign_q, s1_exp_q[EXPONENT-1:0], s1_mant_q[MANTISSA-1:0]};
    f_inv  = 1'b0;
    f_ovf  = 1'b0;
    f_unf  = 1'b0;
    f_inx  = s1_inexact_q;
    f_zero = 1'b0;

    if (a_nan || b_nan) begin
      res_c = QNAN;
      f_inx = 1'b0;
    end else if (a_inf && b_inf && (s1_sa_q ^ s1_sb_q ^ s1_op_q)) begin
      // inf - inf
      res_c = QNAN;
      f_inv = 1'b1;
      f_inx = 1'b0;
    end else if (a_inf) begin
      res_c = {s1_sa_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      f_inx = 1'b0;
    end else if (b_inf) begin
      // B's effective sign flips on subtraction
      res_c = {s1_sb_q ^ s1_op_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      f_inx = 1'b0;
    end else if (exp_ovf) begin
      res_c = {s1_sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      f_ovf = 1'b1;
      f_inx = 1'b1;
    end else if (exp_le0 || mant_zero) begin
      // no subnormal support: flush to signed zero
      res_c  = {s1_sign_q, {(DWIDTH-1){1'b0}}};
      f_unf  = exp_le0 && !mant_zero;
      f_zero = 1'b1;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = res_c;
        s2_flags_d  = {f_inv, f_ovf, f_unf, f_inx, f_zero};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_inexact_q <= 1'b0;
      s1_exc_q     <= '0;
      s1_sa_q      <= 1'b0;
      s1_sb_q      <= 1'b0;
      s1_op_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_flags_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_inexact_q <= s1_inexact_d;
      s1_exc_q     <= s1_exc_d;
      s1_sa_q      <= s1_sa_d;
      s1_sb_q      <= s1_sb_d;
      s1_op_q      <= s1_op_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_flags_q   <= s2_flags_d;
    end
  end

  always_comb begin
    out_valid  = s2_valid_q;
    out_result = s2_result_q;
    out_flags  = s2_flags_q;
  end

endmodule
